// File: rtl/prio_encoder_rr_pkg.sv
// ---------------------------------------------------------------------------
// enc_pkg
// Shared definitions for the round-robin / fixed priority encoder slice.
//   MODE_FIXED : mode value selecting fixed priority (highest index wins)
//   MODE_RR    : mode value selecting descending round-robin rotation
//   idx_w()    : index width for an N-line encoder (at least one bit)
// ---------------------------------------------------------------------------
package enc_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // $clog2(N) for N >= 2; clamped to 1 so degenerate builds still elaborate.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// ---------------------------------------------------------------------------
// prio_encoder_rr_if
// Request side and valid/ready output handshake of the priority encoder.
//   req       : N request lines, bit i = source i
//   mode      : MODE_FIXED / MODE_RR, sampled on every load
//   out_idx   : registered winning index (W bits)
//   out_valid : out_idx carries a winner
//   out_multi : more than one request was set when out_idx was captured
//   out_ready : downstream accepts the current output
// Modports:
//   master : request source + downstream consumer (drives req/mode/out_ready)
//   slave  : the encoder itself
// ---------------------------------------------------------------------------
interface prio_encoder_rr_if #(
  parameter int N = 4
);
  import enc_pkg::*;

  localparam int W = idx_w(N);

  logic [N-1:0] req;
  logic         mode;
  logic [W-1:0] out_idx;
  logic         out_valid;
  logic         out_multi;
  logic         out_ready;

  modport master (
    output req,
    output mode,
    output out_ready,
    input  out_idx,
    input  out_valid,
    input  out_multi
  );

  modport slave (
    input  req,
    input  mode,
    input  out_ready,
    output out_idx,
    output out_valid,
    output out_multi
  );

endinterface

// File: rtl/prio_encoder_rr_find.sv
// ---------------------------------------------------------------------------
// prio_find
// Purely combinational highest-set-bit finder.
//   vec   : input vector, N bits
//   idx   : index of the highest set bit (0 when vec is all zero)
//   found : vec has at least one bit set
// ---------------------------------------------------------------------------
module prio_find
  import enc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          vec,
  output logic [idx_w(N)-1:0]   idx,
  output logic                  found
);

  localparam int W = idx_w(N);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) idx = W'(i);
    end
  end

  assign found = |vec;

endmodule

// File: rtl/prio_encoder_rr.sv
// ---------------------------------------------------------------------------
// prio_encoder_rr
// Registered N-to-log2(N) priority encoder with valid/ready back-pressure and
// selectable fixed-priority or descending round-robin arbitration.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset (clears outputs and ptr)
//   bus : prio_encoder_rr_if.slave (req, mode, out_ready in;
//         out_idx, out_valid, out_multi out)
// The output stage reloads whenever it is empty or being accepted; otherwise
// everything, including the rotation pointer, holds and req is ignored.
// ---------------------------------------------------------------------------
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  prio_encoder_rr_if.slave    bus
);

  localparam int W = idx_w(N);

  logic [W-1:0] idx_p1;
  logic         vld_p1;
  logic         multi_p1;
  logic [W-1:0] ptr_p1;

  logic [N-1:0] req_below;
  logic [W-1:0] below_idx;
  logic         below_found;
  logic [W-1:0] all_idx;
  logic         all_found;
  logic [W-1:0] winner;
  logic         load;

  // Clears the lowest set bit; anything left means two or more requests.
  function automatic logic multi_hot(input logic [N-1:0] v);
    return (v & (v - N'(1))) != '0;
  endfunction

  // Stage 0: combinational arbitration on the live request lines
  always_comb begin
    req_below = '0;
    for (int i = 0; i < N; i++) begin
      req_below[i] = bus.req[i] && (i < int'(ptr_p1));
    end
  end

  prio_find #(.N(N)) u_find_below (
    .vec   (req_below),
    .idx   (below_idx),
    .found (below_found)
  );

  prio_find #(.N(N)) u_find_all (
    .vec   (bus.req),
    .idx   (all_idx),
    .found (all_found)
  );

  // Round-robin prefers the highest request below the last grant and wraps
  // to the overall highest; fixed mode always takes the overall highest.
  always_comb begin
    winner = all_idx;
    if (bus.mode == MODE_RR && below_found) winner = below_idx;
  end

  assign load = !vld_p1 || bus.out_ready;

  // Stage 1: output register and rotation pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_p1   <= '0;
      vld_p1   <= 1'b0;
      multi_p1 <= 1'b0;
      ptr_p1   <= '0;
    end else if (load) begin
      if (all_found) begin
        vld_p1   <= 1'b1;
        idx_p1   <= winner;
        multi_p1 <= multi_hot(bus.req);
        if (bus.mode == MODE_RR) ptr_p1 <= winner;
      end else begin
        vld_p1   <= 1'b0;
        idx_p1   <= '0;
        multi_p1 <= 1'b0;
      end
    end
  end

  assign bus.out_idx   = idx_p1;
  assign bus.out_valid = vld_p1;
  assign bus.out_multi = multi_p1;

endmodule

// File: tb/tb_prio_encoder_rr.sv
module tb_prio_encoder_rr;
  import enc_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  prio_encoder_rr_if #(.N(4)) bus4 ();
  prio_encoder_rr_if #(.N(5)) bus5 ();

  prio_encoder_rr #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  prio_encoder_rr #(.N(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected fixed-priority results for req = 0..15 (N = 4).
  localparam int FIX_IDX   [16] = '{0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3};
  localparam int FIX_MULTI [16] = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};

  task automatic check(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input int v, input int idx, input int m);
    check({tag, ".valid"}, int'(bus4.out_valid), v);
    check({tag, ".idx"},   int'(bus4.out_idx),   idx);
    check({tag, ".multi"}, int'(bus4.out_multi), m);
  endtask

  task automatic chk5(input string tag, input int v, input int idx, input int m);
    check({tag, ".valid"}, int'(bus5.out_valid), v);
    check({tag, ".idx"},   int'(bus5.out_idx),   idx);
    check({tag, ".multi"}, int'(bus5.out_multi), m);
  endtask

  initial begin
    int rr_seq[6];
    int rr5_seq[6];
    n_tests = 0;
    n_fail  = 0;
    rr_seq  = '{3, 2, 1, 0, 3, 2};
    rr5_seq = '{4, 3, 2, 1, 0, 4};

    rst = 1'b1;
    bus4.req = '0; bus4.mode = MODE_FIXED; bus4.out_ready = 1'b1;
    bus5.req = '0; bus5.mode = MODE_FIXED; bus5.out_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Put something into the output register, then reset mid-cycle.
    bus4.req = 4'b1111;
    step();
    chk4("pre_reset", 1, 3, 1);
    #2 rst = 1'b1;
    #1 chk4("async_reset", 0, 0, 0);
    step();
    chk4("reset_held", 0, 0, 0);
    rst = 1'b0;

    // Round-robin on all requests, starting from ptr = 0.
    bus4.mode = MODE_RR;
    for (int k = 0; k < 6; k++) begin
      step();
      chk4($sformatf("rr_full[%0d]", k), 1, rr_seq[k], 1);
    end

    // Fixed-priority sweep (ptr stays at 2).
    bus4.mode = MODE_FIXED;
    for (int v = 0; v < 16; v++) begin
      bus4.req = 4'(v);
      step();
      chk4($sformatf("fixed[%0d]", v), (v != 0) ? 1 : 0, FIX_IDX[v], FIX_MULTI[v]);
    end

    // ptr must still be 2 after fixed mode: next RR grant on 1111 is 1.
    bus4.mode = MODE_RR;
    bus4.req  = 4'b1111;
    step();
    chk4("rr_after_fixed", 1, 1, 1);
    bus4.req = 4'b1000;
    step();
    chk4("rr_wrap_1000", 1, 3, 0);

    // Sparse rotation from ptr = 3.
    bus4.req = 4'b0101;
    step(); chk4("rr_sparse[0]", 1, 2, 1);
    step(); chk4("rr_sparse[1]", 1, 0, 1);
    step(); chk4("rr_sparse[2]", 1, 2, 1);
    bus4.req = 4'b0000;
    step(); chk4("rr_idle[0]", 0, 0, 0);
    bus4.req = 4'b0101;
    step(); chk4("rr_resume_ptr2", 1, 0, 1);
    bus4.req = 4'b0000;
    step(); chk4("rr_idle[1]", 0, 0, 0);
    bus4.req = 4'b0101;
    step(); chk4("rr_resume_ptr0", 1, 2, 1);

    // Stall with idx = 2, ptr = 2; req toggles and must be ignored.
    bus4.out_ready = 1'b0;
    bus4.req = 4'b1000; step(); chk4("stall[0]", 1, 2, 1);
    bus4.req = 4'b0001; step(); chk4("stall[1]", 1, 2, 1);
    bus4.req = 4'b1111; step(); chk4("stall[2]", 1, 2, 1);
    bus4.req = 4'b0000; step(); chk4("stall[3]", 1, 2, 1);
    bus4.out_ready = 1'b1;
    bus4.req = 4'b1101;
    step(); chk4("stall_release", 1, 0, 1);
    bus4.req = 4'b1101;
    step(); chk4("after_release", 1, 3, 1);

    // Empty output loads even with out_ready low.
    bus4.req = 4'b0000;
    step(); chk4("drain", 0, 0, 0);
    bus4.out_ready = 1'b0;
    bus4.mode = MODE_FIXED;
    bus4.req  = 4'b0010;
    step(); chk4("load_when_empty", 1, 1, 0);
    bus4.req = 4'b0000;
    step(); chk4("hold_not_ready", 1, 1, 0);

    // N = 5 build (ptr = 0 after the earlier reset).
    bus5.mode = MODE_FIXED;
    bus5.req  = 5'b10000;
    step(); chk5("n5_fixed_10000", 1, 4, 0);
    bus5.req  = 5'b00111;
    step(); chk5("n5_fixed_00111", 1, 2, 1);
    bus5.mode = MODE_RR;
    bus5.req  = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      step();
      chk5($sformatf("n5_rr[%0d]", k), 1, rr5_seq[k], 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_encoder_rr.md
# prio_encoder_rr

Parametrised, registered N-to-log2(N) priority encoder with a valid/ready output handshake and a selectable fixed-priority or round-robin mode. It generalises the 4-to-2 encoder with a valid flag to any width. It adds a one-cycle registered output, back-pressure and fair rotation. It sits between raw request lines (interrupt/event sources) and a single downstream consumer of the winning index.

## Interface
- `N`, default 4: number of request lines; N ≥ 2, need not be a power of two.
- `W`, default `$clog2(N)`: index width (localparam, not overridable).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input N: request vector, bit i = source i.
- `mode` input 1: 0 = fixed priority (highest index wins), 1 = round-robin.
- `out_idx` output W: encoded winning index.
- `out_valid` output 1: `out_idx` holds a valid winner.
- `out_multi` output 1: more than one request was set when `out_idx` was captured.
- `out_ready` input 1: downstream accepts the current output.

## Operation
- Internal state: `out_idx`, `out_valid`, `out_multi`, and the round-robin pointer `ptr` (W bits).
- load = `!out_valid || out_ready`. The output registers update only on a clock edge where load is true.
- On load with `req != 0`:
  - `out_valid` <= 1.
  - `out_idx` <= winner.
  - `out_multi` <= (popcount(`req`) > 1).
  - if `mode` = 1, `ptr` <= winner.
- On load with `req == 0`:
  - `out_valid` <= 0, `out_idx` <= 0, `out_multi` <= 0.
  - `ptr` unchanged.
- When load is false (stall), all outputs and `ptr` hold, and `req` is ignored. Requests are not latched; a request that drops during a stall is lost.
- Fixed winner: the highest set index of `req`.
- Round-robin winner: the highest set index strictly below `ptr`. If none exists, the highest set index overall. This gives descending rotation with wrap from 0 to N-1.
- `mode` is sampled at each load. `ptr` keeps its value across mode changes; fixed mode neither reads nor updates it.
- Indices ≥ N never appear on `out_idx`.

## Timing
- Reset values, applied asynchronously while `rst` = 1: `out_idx` = 0, `out_valid` = 0, `out_multi` = 0, `ptr` = 0.
- Latency: `req` sampled at edge k appears on the outputs after edge k. One cycle, no bubbles when `out_ready` = 1.
- Throughput: one winner per cycle while `out_ready` = 1.
- Handshake:
  - Transfer occurs on an edge where `out_valid && out_ready`.
  - `out_valid` never drops without a transfer.
  - `out_idx` and `out_multi` are stable while `out_valid && !out_ready`.
  - `out_ready` may be high while `out_valid` is 0.
- Reset release: the first load occurs on the first edge after `rst` deasserts. With `ptr` = 0, round-robin starts at the highest set index.
- Reset asserted mid-transfer: the pending output is discarded and `ptr` returns to 0.

## Structure
- Shared package `enc_pkg`: constants `MODE_FIXED` = 1'b0 and `MODE_RR` = 1'b1.
- Sub-module `prio_find` (parameter N), purely combinational:
  - input: vector.
  - outputs: index of the highest set bit and a `found` flag.
- Instantiate `prio_find` twice: once on `req` masked to indices below `ptr`, once on unmasked `req`. The masked result takes precedence when found.
- Popcount > 1 check is implemented as `(req & (req - 1)) != 0`.

## Test plan
- Reset: assert `rst` asynchronously with `req` = 4'b1111 and `out_ready` = 1. Required: immediately `out_valid` = 0, `out_idx` = 0, `out_multi` = 0. After release, round-robin grants 3 first.
- Fixed mode, N=4, `out_ready` = 1, sweep `req` 4'b0000 to 4'b1111, one per cycle. One cycle later:
  - 0000 gives `out_valid` = 0.
  - 0001 gives `out_idx` = 0.
  - 0110 gives `out_idx` = 2 with `out_multi` = 1.
  - 1010 gives `out_idx` = 3.
  - 1000 gives `out_idx` = 3 with `out_multi` = 0.
- Round-robin, `req` = 4'b1111 held, `out_ready` = 1: `out_idx` sequence is 3, 2, 1, 0, 3, 2 with `out_multi` = 1 throughout.
- Round-robin sparse, `req` = 4'b0101: `out_idx` alternates 2, 0, 2. Then `req` = 0 gives `out_valid` = 0. Then `req` = 4'b0101 again continues from the retained `ptr` (next winner 2 if the last grant was 0).
- Stall: output valid with `out_idx` = 2, `out_ready` = 0 for 3 cycles while `req` toggles. Required: outputs and `ptr` frozen. On `out_ready` = 1, transfer occurs and the next edge loads from the current `req`.
- N=5 parameter build, fixed mode:
  - `req` = 5'b10000 gives `out_idx` = 4.
  - Round-robin on 5'b11111 gives 4, 3, 2, 1, 0, 4; `out_idx` never exceeds 4.
